// File: rtl/engine_start_sequencer_pkg.sv
// Shared definitions for the engine start sequencer: state codes and
// parameter defaults. Package name is car_safety_pkg.
package car_safety_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_ACC   = 3'd1;
  localparam logic [2:0] ST_CRANK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;
  localparam logic [2:0] ST_LOCK  = 3'd5;

  localparam int CRANK_MAX_DEF  = 16;
  localparam int CHIME_HALF_DEF = 4;
  localparam int RETRY_MAX_DEF  = 3;

  // Ignition relay is energised whenever the engine is live or being cranked.
  function automatic logic ign_on(state_t s);
    return (s == ST_ACC) || (s == ST_CRANK) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/engine_start_sequencer_if.sv
// Driver/interlock/relay bundle for the engine start sequencer.
// master = environment driving the inputs, slave = the sequencer.
interface engine_start_sequencer_if;
  import car_safety_pkg::*;

  logic   KEY;
  logic   START_BTN;
  logic   START_PERMIT;
  logic   WARN_PRI1;
  logic   CHIME_REQ;
  logic   ENG_RUN;
  logic   IGN;
  logic   STARTER;
  logic   BUZZER;
  state_t STATE;
  logic   LOCKOUT;

  modport master (
    output KEY, START_BTN, START_PERMIT, WARN_PRI1, CHIME_REQ, ENG_RUN,
    input  IGN, STARTER, BUZZER, STATE, LOCKOUT
  );

  modport slave (
    input  KEY, START_BTN, START_PERMIT, WARN_PRI1, CHIME_REQ, ENG_RUN,
    output IGN, STARTER, BUZZER, STATE, LOCKOUT
  );

endinterface

// File: rtl/engine_start_sequencer_chime_gen.sv
// chime_gen: square-wave buzzer driver. While en is high the output goes
// high one cycle after en is first seen, then toggles every CHIME_HALF
// cycles. Dropping en clears the output and the phase next cycle.
module chime_gen #(
  parameter int CHIME_HALF = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic buzzer
);

  localparam int PW = $clog2(CHIME_HALF + 1);

  logic [PW-1:0] phase;
  logic          armed;

  // Phase counter and buzzer level; the first enabled edge only arms.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase  <= '0;
      armed  <= 1'b0;
      buzzer <= 1'b0;
    end else if (!en) begin
      phase  <= '0;
      armed  <= 1'b0;
      buzzer <= 1'b0;
    end else if (!armed) begin
      phase  <= '0;
      armed  <= 1'b1;
      buzzer <= 1'b1;
    end else if (phase == PW'(CHIME_HALF - 1)) begin
      phase  <= '0;
      buzzer <= ~buzzer;
    end else begin
      phase  <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/engine_start_sequencer.sv
// engine_start_sequencer: key/start-button FSM driving ignition and
// starter relays with a bounded crank window and a pulsed chime.
// Optional macro CRANK_LOCKOUT_EN adds a consecutive-failure counter and
// the LOCK state; without it LOCK is unreachable and LOCKOUT is tied low.
module engine_start_sequencer
  import car_safety_pkg::*;
#(
  parameter int CRANK_MAX  = CRANK_MAX_DEF,
  parameter int CHIME_HALF = CHIME_HALF_DEF,
  parameter int RETRY_MAX  = RETRY_MAX_DEF
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  engine_start_sequencer_if.slave   bus
);

  localparam int CW = $clog2(CRANK_MAX);

  if (CRANK_MAX < 2 || CHIME_HALF < 1 || RETRY_MAX < 1) begin : g_bad_param
    $error("engine_start_sequencer: parameter out of range");
  end

  state_t        state_q, state_d;
  logic          btn_q;
  logic          btn_rise;
  logic [CW-1:0] crank_cnt;
  logic          crank_done;

  assign btn_rise   = bus.START_BTN & ~btn_q;
  assign crank_done = (crank_cnt == CW'(CRANK_MAX - 1));

`ifdef CRANK_LOCKOUT_EN
  localparam int RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_cnt;
  logic          retry_last;
  assign retry_last = (retry_cnt == RW'(RETRY_MAX - 1));
`endif

  // Next-state decode; KEY removal overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (bus.KEY) state_d = ST_ACC;
      ST_ACC:   if (btn_rise && bus.START_PERMIT && !bus.WARN_PRI1) state_d = ST_CRANK;
      ST_CRANK: begin
        if (bus.ENG_RUN)           state_d = ST_RUN;
        else if (!bus.START_PERMIT) state_d = ST_ABORT;
        else if (crank_done)       state_d = ST_ABORT;
      end
      ST_RUN:   if (!bus.ENG_RUN) state_d = ST_ACC;
`ifdef CRANK_LOCKOUT_EN
      ST_ABORT: state_d = retry_last ? ST_LOCK : ST_ACC;
      ST_LOCK:  state_d = ST_LOCK;
`else
      ST_ABORT: state_d = ST_ACC;
`endif
      default:  state_d = ST_OFF;
    endcase
    if (!bus.KEY) state_d = ST_OFF;
  end

  // State register and previous-button sample for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_OFF;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= bus.START_BTN;
    end
  end

  // Crank timer: zero outside CRANK so every crank attempt starts fresh.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                  crank_cnt <= '0;
    else if (state_q != ST_CRANK) crank_cnt <= '0;
    else if (!crank_done)        crank_cnt <= crank_cnt + 1'b1;
  end

`ifdef CRANK_LOCKOUT_EN
  // Consecutive failed cranks; a successful start or key-off forgives them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      retry_cnt <= '0;
    else if (state_d == ST_RUN || state_d == ST_OFF)
      retry_cnt <= '0;
    else if (state_q == ST_ABORT && retry_cnt != RW'(RETRY_MAX))
      retry_cnt <= retry_cnt + 1'b1;
  end
  assign bus.LOCKOUT = (state_q == ST_LOCK);
`else
  assign bus.LOCKOUT = 1'b0;
`endif

  // Relay outputs decode straight from the state register so an
  // asynchronous reset drops the starter without waiting for a clock.
  assign bus.IGN     = ign_on(state_q);
  assign bus.STARTER = (state_q == ST_CRANK);
  assign bus.STATE   = state_q;

  chime_gen #(.CHIME_HALF(CHIME_HALF)) u_chime (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .en     (bus.CHIME_REQ && (state_q != ST_OFF)),
    .buzzer (bus.BUZZER)
  );

endmodule

// File: tb/tb_engine_start_sequencer.sv
// Directed bench for engine_start_sequencer (CRANK_MAX=16, CHIME_HALF=4,
// RETRY_MAX=3). Lockout expectations follow CRANK_LOCKOUT_EN.
module tb_engine_start_sequencer;
  import car_safety_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   failures = 0;

  engine_start_sequencer_if bus();

  engine_start_sequencer #(.CRANK_MAX(16), .CHIME_HALF(4), .RETRY_MAX(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

`ifdef CRANK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Press the button from a released state: one cycle low, then high.
  task automatic press();
    bus.START_BTN = 1'b0;
    tick();
    bus.START_BTN = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    logic [19:0] pat, pat_exp;

    RST_N            = 1'b0;
    bus.KEY          = 1'b0;
    bus.START_BTN    = 1'b0;
    bus.START_PERMIT = 1'b0;
    bus.WARN_PRI1    = 1'b0;
    bus.CHIME_REQ    = 1'b0;
    bus.ENG_RUN      = 1'b0;
    #12;
    chk("rst_state",   bus.STATE,   0);
    chk("rst_ign",     bus.IGN,     0);
    chk("rst_starter", bus.STARTER, 0);
    chk("rst_buzzer",  bus.BUZZER,  0);
    chk("rst_lockout", bus.LOCKOUT, 0);
    RST_N = 1'b1;
    tick();
    chk("off_hold", bus.STATE, 0);

    // Normal start: engine catches on the fifth crank cycle.
    bus.KEY = 1'b1;
    bus.START_PERMIT = 1'b1;
    tick();
    chk("acc_state", bus.STATE, 1);
    chk("acc_ign",   bus.IGN,   1);
    bus.START_BTN = 1'b1;
    tick();
    chk("crank_entry",   bus.STATE,   2);
    chk("crank_starter", bus.STARTER, 1);
    n = 0;
    while (bus.STATE == 2 && n < 40) begin
      n++;
      if (n == 5) bus.ENG_RUN = 1'b1;
      tick();
    end
    chk("start_cycles", n, 5);
    chk("run_state",    bus.STATE,   3);
    chk("run_ign",      bus.IGN,     1);
    chk("run_starter",  bus.STARTER, 0);
    bus.ENG_RUN = 1'b0;
    tick();
    chk("stall_acc", bus.STATE, 1);
    bus.START_BTN = 1'b0;
    tick();

    // Warning inhibits the crank; a held button after it clears is not an edge.
    bus.WARN_PRI1 = 1'b1;
    seen = 0;
    bus.START_BTN = 1'b1;
    tick(); seen |= bus.STARTER;
    bus.START_BTN = 1'b0;
    tick(); seen |= bus.STARTER;
    bus.START_BTN = 1'b1;
    tick(); seen |= bus.STARTER;
    chk("warn_stay", bus.STATE, 1);
    bus.WARN_PRI1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= bus.STARTER;
    end
    chk("held_btn_state", bus.STATE, 1);
    chk("warn_no_starter", seen, 0);

    // Three timed-out cranks.
    for (int a = 0; a < 3; a++) begin
      press();
      chk("to_crank", bus.STATE, 2);
      n = 0;
      while (bus.STATE == 2 && n < 40) begin
        n++;
        tick();
      end
      chk("timeout_cycles", n, 16);
      chk("abort_state", bus.STATE, 4);
      chk("abort_ign",   bus.IGN,   0);
      tick();
      chk("after_abort", bus.STATE, (LOCK_EN && a == 2) ? 5 : 1);
      chk("lockout",     bus.LOCKOUT, (LOCK_EN && a == 2) ? 1 : 0);
    end
    bus.KEY = 1'b0;
    tick();
    chk("keyoff_state",   bus.STATE,   0);
    chk("keyoff_lockout", bus.LOCKOUT, 0);
    chk("keyoff_ign",     bus.IGN,     0);

    // KEY=0 wins over ENG_RUN in the same crank cycle.
    bus.KEY = 1'b1;
    tick();
    press();
    chk("crank2", bus.STATE, 2);
    bus.KEY = 1'b0;
    bus.ENG_RUN = 1'b1;
    tick();
    chk("key_over_run_state", bus.STATE, 0);
    chk("key_over_run_ign",   bus.IGN,   0);
    bus.ENG_RUN = 1'b0;
    bus.START_BTN = 1'b0;

    // Chime in ACC: 4 high / 4 low.
    bus.KEY = 1'b1;
    tick();
    chk("chime_acc", bus.STATE, 1);
    chk("chime_idle", bus.BUZZER, 0);
    bus.CHIME_REQ = 1'b1;
    pat = '0;
    pat_exp = 20'b0000_1111_0000_1111_0000 | 20'b1111_0000_1111_0000_1111;
    pat_exp = 20'b1111_0000_1111_0000_1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      pat[i] = bus.BUZZER;
    end
    chk("chime_pattern", pat, pat_exp);
    bus.CHIME_REQ = 1'b0;
    tick();
    chk("chime_off", bus.BUZZER, 0);

    // Asynchronous reset in the middle of a crank.
    press();
    chk("crank3", bus.STARTER, 1);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_starter", bus.STARTER, 0);
    chk("async_state",   bus.STATE,   0);
    chk("async_ign",     bus.IGN,     0);
    #10;
    RST_N = 1'b1;
    tick();
    chk("resume_acc", bus.STATE, 1);
    chk("resume_no_crank", bus.STARTER, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/engine_start_sequencer.md
ENGINE_START_SEQUENCER -- requirements
Module: engine_start_sequencer

Interface
REQ-001 Parameter CRANK_MAX, default 16, crank timeout in CLK cycles (>=2).
REQ-002 Parameter CHIME_HALF, default 4, buzzer half-period in CLK cycles (>=1).
REQ-003 Parameter RETRY_MAX, default 3, consecutive failed cranks before lockout (>=1).
REQ-004 CLK  in  1  single system clock, rising edge; one clock, reset asynchronous active-low.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 KEY  in  1  key inserted/turned.
REQ-007 START_BTN  in  1  driver start button, level.
REQ-008 START_PERMIT  in  1  start permission from interlock logic.
REQ-009 WARN_PRI1  in  1  priority-1 warning active.
REQ-010 CHIME_REQ  in  1  chime demand from interlock logic.
REQ-011 ENG_RUN  in  1  engine-running feedback.
REQ-012 IGN  out  1  ignition relay.
REQ-013 STARTER  out  1  starter motor relay.
REQ-014 BUZZER  out  1  pulsed chime driver.
REQ-015 STATE  out  3  current FSM state encoding.
REQ-016 LOCKOUT  out  1  crank lockout indicator.

Function
REQ-017 States SHALL be OFF=0, ACC=1, CRANK=2, RUN=3, ABORT=4, LOCK=5; codes 6-7 SHALL return to OFF next cycle.
REQ-018 KEY=0 in any state SHALL force OFF next cycle, overriding every other transition.
REQ-019 OFF: KEY=1 -> ACC.
REQ-020 ACC: START_BTN rising edge (registered previous value) with START_PERMIT=1 and WARN_PRI1=0 -> CRANK next cycle; otherwise stay.
REQ-021 CRANK: crank counter cleared on entry; ENG_RUN=1 -> RUN; else START_PERMIT=0 -> ABORT; else counter = CRANK_MAX-1 -> ABORT; ENG_RUN takes priority over timeout in the same cycle.
REQ-022 ABORT: one cycle, then ACC (or LOCK per REQ-031).
REQ-023 RUN: ENG_RUN=0 (stall) -> ACC.
REQ-024 LOCK: exits only via KEY=0.
REQ-025 Outputs Moore-decoded from state register: IGN=1 in ACC, CRANK, RUN; STARTER=1 only in CRANK; LOCKOUT=1 only in LOCK; STATE equals state register.
REQ-026 STARTER SHALL never be high more than CRANK_MAX consecutive cycles.
REQ-027 BUZZER: while CHIME_REQ=1 and state != OFF, toggles every CHIME_HALF cycles starting at 1 on first asserted cycle+1; CHIME_REQ=0 or OFF clears BUZZER and phase counter next cycle.

Reset
REQ-028 RST_N=0 SHALL asynchronously set state OFF, IGN=0, STARTER=0, BUZZER=0, LOCKOUT=0, all counters and the button-edge register to 0.
REQ-029 Reset mid-CRANK SHALL drop STARTER within the same cycle as RST_N assertion; release resumes from OFF.

Configuration
REQ-030 Macro CRANK_LOCKOUT_EN SHALL gate the retry counter and LOCK state.
REQ-031 Defined: ABORT increments retry count; count reaching RETRY_MAX -> LOCK; entry to RUN or OFF clears count.
REQ-032 Undefined: no retry counter, ABORT always -> ACC, LOCK unreachable, LOCKOUT tied 0.

Structure
REQ-033 State encoding typedef and parameter defaults SHALL live in shared package car_safety_pkg.
REQ-034 Buzzer phase counter SHALL be sub-module chime_gen; FSM and crank/retry counters stay in top.

Verification
REQ-035 Reset, KEY=1, START_PERMIT=1, START_BTN 0->1, ENG_RUN=1 at crank cycle 5 -> STATE 0,1,2..., STARTER high exactly 5 cycles, then STATE=3, IGN=1.
REQ-036 ACC, WARN_PRI1=1, START_BTN pulse -> STATE stays 1, STARTER never 1; button held high after WARN clears -> no crank (edge only).
REQ-037 CRANK_MAX=16, ENG_RUN=0 -> STARTER high 16 cycles, ABORT one cycle, ACC; with CRANK_LOCKOUT_EN three failures -> STATE=5, LOCKOUT=1; KEY=0 -> OFF, LOCKOUT=0.
REQ-038 CRANK with KEY=0 and ENG_RUN=1 same cycle -> OFF next cycle, IGN=0.
REQ-039 CHIME_REQ=1 in ACC for 20 cycles, CHIME_HALF=4 -> BUZZER 4 high/4 low pattern; CHIME_REQ=0 -> BUZZER 0 next cycle.
REQ-040 RST_N asserted mid-CRANK between clock edges -> STARTER=0 immediately, STATE=0.
